obuf_writeback: RTL



---
 rtl/obuf_wb_pkg.sv | 14 +
 rtl/obuf_wb_if.sv | 12 +
 rtl/wb_fifo.sv | 49 ++++
 rtl/obuf_writeback.sv | 134 +++++++++++++
 4 files changed

// File: rtl/obuf_wb_pkg.sv
// Shared types and defaults for the obuf writeback drain engine.
package obuf_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } wb_state_e;

    localparam int DEFAULT_BURST_LEN  = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/obuf_wb_if.sv
// Valid/ready write-data stream carrying drained obuf words towards the DDR write channel.
interface obuf_wb_if #(
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous skid FIFO; one entry holds a data word plus its last flag.
module wb_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count define validity, and dout is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/obuf_writeback.sv
// Drains a contiguous obuf word range through the memory-side read port into a
// burst-marked valid/ready write-data stream.
module obuf_writeback
    import obuf_wb_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int COUNT_W        = 16,
    parameter int BURST_LEN      = DEFAULT_BURST_LEN,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [COUNT_W-1:0]        cfg_num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_read_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
    obuf_wb_if.master                 wr
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int BURST_W = $clog2(BURST_LEN);

    wb_state_e               state;
    logic [COUNT_W-1:0]      num_words;
    logic [COUNT_W-1:0]      issued;
    logic [COUNT_W-1:0]      returned;
    logic [COUNT_W-1:0]      sent;
    logic                    data_valid;   // read issued last cycle, its data arrives now
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        count_next;
    logic [MEM_DATA_WIDTH:0] fifo_dout;
    logic                    push_last;
    logic                    can_issue;
    logic                    last_pop;

    wb_fifo #(
        .WIDTH (MEM_DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_valid),
        .pop   (fifo_pop),
        .din   ({push_last, mem_read_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign wr.wr_valid            = ~fifo_empty;
    assign {wr.wr_last, wr.wr_data} = fifo_dout;
    assign fifo_pop               = wr.wr_valid & wr.wr_ready;

    // NOTE: each always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        push_last  = (returned[BURST_W-1:0] == BURST_W'(BURST_LEN - 1)) ||
                     (returned == num_words - COUNT_W'(1));
        count_next = fifo_count + CNT_W'(data_valid) - CNT_W'(fifo_pop);
        // Next cycle's read is allowed if buffered words plus the read now in flight leave a free slot.
        can_issue  = (32'(count_next) + 32'(mem_read_req)) < 32'(FIFO_DEPTH);
        last_pop   = fifo_pop && (sent == num_words - COUNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_read_req  <= 1'b0;
            mem_read_addr <= '0;
            data_valid    <= 1'b0;
            num_words     <= '0;
            issued        <= '0;
            returned      <= '0;
            sent          <= '0;
        end else begin
            assert (!(data_valid && fifo_full && !fifo_pop));
            data_valid <= mem_read_req;
            if (mem_read_req) mem_read_addr <= mem_read_addr + MEM_ADDR_WIDTH'(1);
            if (data_valid)   returned      <= returned + COUNT_W'(1);
            if (fifo_pop)     sent          <= sent + COUNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (cfg_num_words == '0) begin
                            state <= ST_DONE;
                        end else begin
                            num_words     <= cfg_num_words;
                            mem_read_addr <= cfg_base_addr;
                            mem_read_req  <= 1'b1;
                            issued        <= COUNT_W'(1);
                            returned      <= '0;
                            sent          <= '0;
                            state         <= (cfg_num_words == COUNT_W'(1)) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    mem_read_req <= can_issue;
                    if (can_issue) begin
                        issued <= issued + COUNT_W'(1);
                        if (issued + COUNT_W'(1) == num_words) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    mem_read_req <= 1'b0;
                    if (last_pop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Arriving with done low (zero-length start) spends one cycle before pulsing.
                    busy <= 1'b0;
                    done <= ~done;
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
